// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving a phase-accumulator DDS (increment + enable).
// Optional triangle (up then down) sweep when DDS_SWEEP_BIDIR_EN is defined.
module dds_sweep_ctrl #(
  parameter int PHASE_WIDTH = 8,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [PHASE_WIDTH-1:0] cfg_start_inc_i,
  input  logic [PHASE_WIDTH-1:0] cfg_stop_inc_i,
  input  logic [PHASE_WIDTH-1:0] cfg_step_i,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
  input  logic                   cfg_cont_i,
  output logic                   en_o,
  output logic [PHASE_WIDTH-1:0] phase_inc_o,
  output logic                   step_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [DWELL_WIDTH-1:0] r_cnt;
  logic                   r_step_pls;
  logic                   r_done;
  logic [PHASE_WIDTH-1:0] r_cfg_start;
  logic [PHASE_WIDTH-1:0] r_cfg_stop;
  logic [PHASE_WIDTH-1:0] r_cfg_step;
  logic [DWELL_WIDTH-1:0] r_cfg_dwell;
  logic                   r_cfg_cont;

  logic [PHASE_WIDTH-1:0] w_phase_nxt;
  logic [DWELL_WIDTH-1:0] w_cnt_nxt;
  logic                   w_step_nxt;
  logic                   w_done_nxt;
  logic                   w_cap;
  logic                   w_last;
  logic                   w_step_nz;
  logic [PHASE_WIDTH:0]   w_up_sum;
  logic                   w_up_ok;
  logic                   w_adv;
  logic [PHASE_WIDTH-1:0] w_adv_val;
  logic                   w_complete;

  assign w_last    = (r_cnt == r_cfg_dwell);
  assign w_step_nz = (r_cfg_step != {PHASE_WIDTH{1'b0}});
  // Extra MSB keeps the sum from wrapping, so overshoot past the top of range ends the sweep.
  assign w_up_sum  = {1'b0, r_phase} + {1'b0, r_cfg_step};
  assign w_up_ok   = w_step_nz && (w_up_sum <= {1'b0, r_cfg_stop});

`ifdef DDS_SWEEP_BIDIR_EN
  logic                 r_down;
  logic                 w_down_nxt;
  logic [PHASE_WIDTH:0] w_dn_diff;
  logic                 w_dn_ok;
  logic                 w_go_down;

  assign w_dn_diff = {1'b0, r_phase} - {1'b0, r_cfg_step};
  assign w_dn_ok   = w_step_nz && ($signed(w_dn_diff) >= $signed({1'b0, r_cfg_start}));
  assign w_go_down = r_down || !w_up_ok;
  assign w_adv     = r_down ? w_dn_ok : (w_up_ok || w_dn_ok);
  assign w_adv_val = w_go_down ? w_dn_diff[PHASE_WIDTH-1:0] : w_up_sum[PHASE_WIDTH-1:0];
`else
  assign w_adv     = w_up_ok;
  assign w_adv_val = w_up_sum[PHASE_WIDTH-1:0];
`endif

  assign w_complete = w_last && !w_adv;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i) w_state_nxt = ST_RUN;
        else                    w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (stop_i)                          w_state_nxt = ST_IDLE;
        else if (w_complete && !r_cfg_cont)  w_state_nxt = ST_IDLE;
        else                                 w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cap       = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
    w_down_nxt  = r_down;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          w_cap       = 1'b1;
          w_phase_nxt = cfg_start_inc_i;
          w_cnt_nxt   = {DWELL_WIDTH{1'b0}};
          w_step_nxt  = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          w_down_nxt  = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          w_cnt_nxt = {DWELL_WIDTH{1'b0}};
        end else if (!w_last) begin
          w_cnt_nxt = r_cnt + {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
        end else if (w_adv) begin
          w_phase_nxt = w_adv_val;
          w_cnt_nxt   = {DWELL_WIDTH{1'b0}};
          w_step_nxt  = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          w_down_nxt  = w_go_down;
`endif
        end else begin
          // Sweep complete: flag it, and in continuous mode restart from the captured start.
          w_done_nxt = 1'b1;
          w_cnt_nxt  = {DWELL_WIDTH{1'b0}};
`ifdef DDS_SWEEP_BIDIR_EN
          w_down_nxt = 1'b0;
`endif
          if (r_cfg_cont) begin
            w_phase_nxt = r_cfg_start;
            w_step_nxt  = 1'b1;
          end else begin
            w_phase_nxt = r_phase;
          end
        end
      end
      default: w_cnt_nxt = {DWELL_WIDTH{1'b0}};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_phase     <= {PHASE_WIDTH{1'b0}};
      r_cnt       <= {DWELL_WIDTH{1'b0}};
      r_step_pls  <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_start <= {PHASE_WIDTH{1'b0}};
      r_cfg_stop  <= {PHASE_WIDTH{1'b0}};
      r_cfg_step  <= {PHASE_WIDTH{1'b0}};
      r_cfg_dwell <= {DWELL_WIDTH{1'b0}};
      r_cfg_cont  <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      r_down      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_step_pls <= w_step_nxt;
      r_done     <= w_done_nxt;
`ifdef DDS_SWEEP_BIDIR_EN
      r_down     <= w_down_nxt;
`endif
      if (w_cap) begin
        r_cfg_start <= cfg_start_inc_i;
        r_cfg_stop  <= cfg_stop_inc_i;
        r_cfg_step  <= cfg_step_i;
        r_cfg_dwell <= cfg_dwell_i;
        r_cfg_cont  <= cfg_cont_i;
      end
    end
  end

  assign en_o        = (r_state == ST_RUN);
  assign busy_o      = (r_state == ST_RUN);
  assign phase_inc_o = r_phase;
  assign step_o      = r_step_pls;
  assign done_o      = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed test-plan cases plus random stimulus
// compared cycle by cycle against a sweep-list reference model.
module tb_dds_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rstn, start, stop, cont;
  logic [7:0] c_start, c_stop, c_step, c_dwell;
  logic       en_o, step_o, busy_o, done_o;
  logic [7:0] phase_inc_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.PHASE_WIDTH(8), .DWELL_WIDTH(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
    .cfg_start_inc_i(c_start), .cfg_stop_inc_i(c_stop), .cfg_step_i(c_step),
    .cfg_dwell_i(c_dwell), .cfg_cont_i(cont),
    .en_o(en_o), .phase_inc_o(phase_inc_o), .step_o(step_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each cycle's expected outputs, derived from the list of sweep values.
  typedef struct { bit en; int ph; bit st; bit dn; } rec_t;
  rec_t q[$];
  rec_t cur;
  int   m_s, m_e, m_d, m_w;
  bit   m_c;

  function automatic void push_sweep(bit first_done);
    int vals[$];
    int v;
    v = m_s;
    forever begin
      vals.push_back(v);
      if (m_d == 0 || v + m_d > m_e) break;
      v += m_d;
    end
`ifdef DDS_SWEEP_BIDIR_EN
    if (m_d != 0) begin
      v = vals[$] - m_d;
      while (v >= m_s) begin
        vals.push_back(v);
        v -= m_d;
      end
    end
`endif
    foreach (vals[i])
      for (int k = 0; k <= m_w; k++)
        q.push_back('{en: 1'b1, ph: vals[i], st: (k == 0), dn: (i == 0 && k == 0) ? first_done : 1'b0});
    if (!m_c) q.push_back('{en: 1'b0, ph: vals[$], st: 1'b0, dn: 1'b1});
  endfunction

  function automatic void model_step();
    if (!rstn) begin
      q.delete();
      cur = '{en: 1'b0, ph: 0, st: 1'b0, dn: 1'b0};
    end else if (cur.en) begin
      if (stop) begin
        q.delete();
        cur = '{en: 1'b0, ph: cur.ph, st: 1'b0, dn: 1'b0};
      end else begin
        if (q.size() == 0) push_sweep(1'b1);
        cur = q.pop_front();
      end
    end else if (start && !stop) begin
      m_s = c_start; m_e = c_stop; m_d = c_step; m_w = c_dwell; m_c = cont;
      q.delete();
      push_sweep(1'b0);
      cur = q.pop_front();
    end else begin
      q.delete();
      cur = '{en: 1'b0, ph: cur.ph, st: 1'b0, dn: 1'b0};
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("en",    en_o,        cur.en);
    check_eq("busy",  busy_o,      cur.en);
    check_eq("phase", phase_inc_o, cur.ph);
    check_eq("step",  step_o,      cur.st);
    check_eq("done",  done_o,      cur.dn);
    @(negedge clk);
  endtask

  task automatic run_sweep(input int s, input int e, input int d, input int w, input bit c, input int n);
    c_start = s[7:0]; c_stop = e[7:0]; c_step = d[7:0]; c_dwell = w[7:0]; cont = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble cfg while running; captured values must be unaffected.
    c_start = 8'd99; c_stop = 8'd1; c_step = 8'd0; c_dwell = 8'd7;
    repeat (n) tick();
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
    c_start = 8'd0; c_stop = 8'd0; c_step = 8'd0; c_dwell = 8'd0;
    cur = '{en: 1'b0, ph: 0, st: 1'b0, dn: 1'b0};
    @(negedge clk);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    run_sweep(10, 40, 10, 2, 1'b0, 15);
    run_sweep(10, 40, 12, 0, 1'b0, 5);
    run_sweep(250, 255, 10, 1, 1'b0, 4);
    run_sweep(40, 10, 5, 1, 1'b0, 4);
    run_sweep(7, 50, 0, 0, 1'b0, 3);
    run_sweep(0, 2, 1, 0, 1'b1, 10);
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();

    c_start = 8'd5; c_stop = 8'd9; c_step = 8'd1; c_dwell = 8'd0;
    start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0; repeat (2) tick();

    run_sweep(10, 30, 10, 0, 1'b0, 3);
    rstn = 1'b0; tick(); rstn = 1'b1;
    repeat (2) tick();

    run_sweep(10, 30, 10, 0, 1'b0, 8);
    run_sweep(0, 2, 1, 0, 1'b1, 2);
    start = 1'b1; repeat (4) tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      rstn  = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) begin
        c_start = 8'($urandom_range(0, 255));
        c_stop  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'((int'(c_start) + $urandom_range(0, 60) > 255) ? 255 : int'(c_start) + $urandom_range(0, 60));
        c_step  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 20));
        c_dwell = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
        cont    = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the phase-increment and enable inputs of the team's phase-accumulator DDS.
- Steps the increment linearly from a start value to a stop value.
- Holds each value for a programmable dwell.
- Runs either one sweep or continuous repeating sweeps.
- Sits between the register/config layer and the DDS; owns the DDS en and phase_inc exclusively.

Parameters:
PHASE_WIDTH, 8, width of phase increment values (matches DDS PHASE_WIDTH)
DWELL_WIDTH, 8, width of dwell counter; each step lasts cfg_dwell_i+1 cycles

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
start_i  in  1  start sweep pulse; honoured only in IDLE
stop_i  in  1  abort; wins over start_i
cfg_start_inc_i  in  PHASE_WIDTH  first increment
cfg_stop_inc_i  in  PHASE_WIDTH  upper bound increment (inclusive)
cfg_step_i  in  PHASE_WIDTH  increment delta per step
cfg_dwell_i  in  DWELL_WIDTH  cycles-per-step minus one
cfg_cont_i  in  1  1 = restart sweep after completion
en_o  out  1  DDS enable
phase_inc_o  out  PHASE_WIDTH  DDS phase increment
step_o  out  1  1-cycle pulse on first cycle of each new increment value
busy_o  out  1  high in RUN
done_o  out  1  1-cycle pulse when a sweep completes

Behaviour:
Reset and clocking:
- One clock, clk_i. Reset is synchronous and active-low on rstn_i.
- Reset values: state IDLE; en_o, step_o, busy_o, done_o all 0; phase_inc_o 0; dwell counter 0.

Configuration capture:
- All cfg_* inputs are latched internally on the accepted start_i.
- cfg changes during RUN have no effect until the next start.
- cfg_cont_i is also captured at start.

States:
- IDLE: en_o=0, busy_o=0; phase_inc_o holds its last value. start_i=1 and stop_i=0 -> RUN.
- RUN: en_o=1, busy_o=1.

Start timing:
- start_i sampled at cycle N -> at cycle N+1: phase_inc_o=start, step_o=1, en_o=1.

Dwell and stepping:
- Each increment value is presented for exactly cfg_dwell+1 cycles. Dwell 0 gives 1 cycle.
- At the last dwell cycle, compute next = cur + step in PHASE_WIDTH+1 bits (no wrap).
- If step != 0 and next <= stop: next cycle phase_inc_o=next[PHASE_WIDTH-1:0], step_o=1, dwell counter reloads.
- Otherwise the sweep is complete. On the next cycle, done_o=1 and:
  - cfg_cont=0: state IDLE, en_o=0.
  - cfg_cont=1: stay RUN, phase_inc_o=start, step_o=1.
- Degenerate configs: start>stop or step=0 -> one dwell at start, then complete.

Abort and priority:
- stop_i in RUN: next cycle IDLE, en_o=0, busy_o=0, no done_o, no step_o.
- stop_i in IDLE: no effect.
- start_i in RUN: ignored.
- stop_i coincident with the sweep-complete cycle: abort wins, no done_o.

Reset mid-sweep: same as the reset values above; no done_o.

Latency: start-to-en_o is 1 cycle; stop-to-en_o-low is 1 cycle.

Optional Feature:
DDS_SWEEP_BIDIR_EN
- Defined: triangle sweep.
  - After the upward sweep reaches its last value, stepping continues downward by step.
  - Downward condition: next = cur - step, valid while next >= start (signed compare, PHASE_WIDTH+1 bits).
  - The peak value is not repeated. The sweep completes after the value equal to the last value >= start is dwelt.
  - done_o and continuous restart then apply as above; the restart begins upward from start.
  - Degenerate configs behave as without the macro.
- Undefined: upward-only sawtooth as described in Behaviour; no direction logic synthesised.

Test Plan:
- start=10, stop=40, step=10, dwell=2, cont=0 -> phase_inc_o 10,20,30,40, each held 3 cycles; en_o high 12 cycles; 4 step_o pulses; done_o on cycle 13 after start with en_o=0.
- start=10, stop=40, step=12, dwell=0 -> values 10,22,34 (46>40 ends sweep); done_o follows 34.
- start=250, stop=255, step=10, width 8 -> single value 250 then done; no wrap to 4.
- cont=1, start=0, stop=2, step=1, dwell=0 -> 0,1,2,0,1,2…; done_o pulses coincide with each return to 0; stop_i mid-sweep -> en_o=0 next cycle, no done_o.
- stop_i and start_i same cycle in IDLE -> stays IDLE; rstn_i=0 during RUN -> all outputs 0 next cycle.
- (BIDIR_EN) start=10, stop=30, step=10, dwell=0 -> 10,20,30,20,10, then done_o.
